// File: rtl/comb_agc_pkg.sv
// comb_agc_pkg
//   Shared definitions for the multi-channel combiner AGC loop register bank:
//   register indices, CONTROL bit positions, reset values and a byte-lane
//   merge helper.
package comb_agc_pkg;

  // Register index (addr[4:2])
  localparam logic [2:0] REG_CONTROL  = 3'd0;
  localparam logic [2:0] REG_SETPOINT = 3'd1;
  localparam logic [2:0] REG_GAINS    = 3'd2;
  localparam logic [2:0] REG_ULIMIT   = 3'd3;
  localparam logic [2:0] REG_LLIMIT   = 3'd4;
  localparam logic [2:0] REG_INT0     = 3'd5;
  localparam logic [2:0] REG_INT1     = 3'd6;
  localparam logic [2:0] REG_SQUELCH  = 3'd7;

  // CONTROL bit positions
  localparam int unsigned CTL_ZERO    = 0;
  localparam int unsigned CTL_INVERT  = 1;
  localparam int unsigned CTL_COMMIT  = 2;
  localparam int unsigned CTL_SNAP    = 3;
  localparam int unsigned CTL_PENDING = 8;
  localparam int unsigned CTL_LIMERR  = 9;

  // Reset values, shared by shadow and active copies
  localparam logic [7:0]  SETPOINT_RST = 8'hE0;
  localparam logic [4:0]  GAIN_RST     = 5'h1B;
  localparam logic [31:0] ULIMIT_RST   = 32'h4FFF_FFFF;
  localparam logic [31:0] LLIMIT_RST   = 32'h0000_0000;
  localparam logic [12:0] SQLVL_RST    = 13'h100;
  localparam logic [15:0] SQRATIO_RST  = 16'h0042;

  // Replace the bytes of cur selected by lanes with the matching bytes of wdata
  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (lanes[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/comb_agc_chan_regs.sv
// comb_agc_chan_regs
//   One AGC loop channel: bus-side shadow registers, active registers copied
//   from the shadows on a committed loop strobe, commit pending / limit error
//   state, and the coherent integrator snapshot pair.
// Ports
//   busClk, busRstN   clock, async active-low reset
//   wrLane[3:0]       byte-lane write enables, already qualified by cs and channel
//   regIdx            register index of the access
//   dataIn            write data
//   loopUpdate        this channel's loop sample strobe
//   integrator0/1     live integrators
//   readData          combinational readback of regIdx for this channel
//   agcSetpoint .. squelchRatio   active register set
//   committed         one-cycle pulse when the active set is updated
module comb_agc_chan_regs
  import comb_agc_pkg::*;
#(
  parameter int unsigned INT_W = 32
) (
  input  logic             busClk,
  input  logic             busRstN,
  input  logic [3:0]       wrLane,
  input  logic [2:0]       regIdx,
  input  logic [31:0]      dataIn,
  input  logic             loopUpdate,
  input  logic [INT_W-1:0] integrator0,
  input  logic [INT_W-1:0] integrator1,
  output logic [31:0]      readData,
  output logic [7:0]       agcSetpoint,
  output logic             invertError,
  output logic             zeroError,
  output logic [4:0]       posErrorGain,
  output logic [4:0]       negErrorGain,
  output logic [31:0]      upperLimit,
  output logic [31:0]      lowerLimit,
  output logic [12:0]      squelchLvl,
  output logic [15:0]      squelchRatio,
  output logic             committed
);

  logic [7:0]       shSetpoint;
  logic [4:0]       shPosGain;
  logic [4:0]       shNegGain;
  logic [31:0]      shUpper;
  logic [31:0]      shLower;
  logic [12:0]      shSqLvl;
  logic [15:0]      shSqRatio;
  logic             pending;
  logic             limitErr;
  logic [INT_W-1:0] snap0;
  logic [INT_W-1:0] snap1;

  logic ctlWr0;
  logic commitReq;
  logic snapReq;
  logic limClr;
  logic apply;
  logic limitsOk;

  assign ctlWr0    = wrLane[0] && (regIdx == REG_CONTROL);
  assign commitReq = ctlWr0 && dataIn[CTL_COMMIT];
  assign snapReq   = ctlWr0 && dataIn[CTL_SNAP];
  assign limClr    = wrLane[1] && (regIdx == REG_CONTROL) && dataIn[CTL_LIMERR];
  assign apply     = pending && loopUpdate;
  assign limitsOk  = (shLower <= shUpper);

  // Bus-side shadows
  always_ff @(posedge busClk or negedge busRstN) begin
    if (!busRstN) begin
      shSetpoint <= SETPOINT_RST;
      shPosGain  <= GAIN_RST;
      shNegGain  <= GAIN_RST;
      shUpper    <= ULIMIT_RST;
      shLower    <= LLIMIT_RST;
      shSqLvl    <= SQLVL_RST;
      shSqRatio  <= SQRATIO_RST;
    end else begin
      if (regIdx == REG_SETPOINT && wrLane[0]) shSetpoint <= dataIn[7:0];
      if (regIdx == REG_GAINS) begin
        if (wrLane[0]) shPosGain <= dataIn[4:0];
        if (wrLane[2]) shNegGain <= dataIn[20:16];
      end
      if (regIdx == REG_ULIMIT) shUpper <= lane_merge(shUpper, dataIn, wrLane);
      if (regIdx == REG_LLIMIT) shLower <= lane_merge(shLower, dataIn, wrLane);
      if (regIdx == REG_SQUELCH) begin
        if (wrLane[0]) shSqLvl[7:0]    <= dataIn[7:0];
        if (wrLane[1]) shSqLvl[12:8]   <= dataIn[12:8];
        if (wrLane[2]) shSqRatio[7:0]  <= dataIn[23:16];
        if (wrLane[3]) shSqRatio[15:8] <= dataIn[31:24];
      end
    end
  end

  // Active set, commit handshake, direct controls and snapshots.
  // A COMMIT arriving while already pending (including on the applying
  // strobe itself) is absorbed into the outstanding request.
  always_ff @(posedge busClk or negedge busRstN) begin
    if (!busRstN) begin
      agcSetpoint  <= SETPOINT_RST;
      posErrorGain <= GAIN_RST;
      negErrorGain <= GAIN_RST;
      upperLimit   <= ULIMIT_RST;
      lowerLimit   <= LLIMIT_RST;
      squelchLvl   <= SQLVL_RST;
      squelchRatio <= SQRATIO_RST;
      invertError  <= 1'b0;
      zeroError    <= 1'b0;
      pending      <= 1'b0;
      limitErr     <= 1'b0;
      committed    <= 1'b0;
      snap0        <= '0;
      snap1        <= '0;
    end else begin
      committed <= 1'b0;
      if (ctlWr0) begin
        zeroError   <= dataIn[CTL_ZERO];
        invertError <= dataIn[CTL_INVERT];
      end
      if (snapReq) begin
        snap0 <= integrator0;
        snap1 <= integrator1;
      end
      // Clear first so a failing apply in the same cycle still sets the flag
      if (limClr) limitErr <= 1'b0;
      if (apply) begin
        pending <= 1'b0;
        if (limitsOk) begin
          agcSetpoint  <= shSetpoint;
          posErrorGain <= shPosGain;
          negErrorGain <= shNegGain;
          upperLimit   <= shUpper;
          lowerLimit   <= shLower;
          squelchLvl   <= shSqLvl;
          squelchRatio <= shSqRatio;
          committed    <= 1'b1;
        end else begin
          limitErr <= 1'b1;
        end
      end else if (commitReq) begin
        pending <= 1'b1;
      end
    end
  end

  // Readback: shadows for the writable registers, snapshots zero-extended
  always_comb begin
    readData = '0;
    case (regIdx)
      REG_CONTROL: begin
        readData[CTL_ZERO]    = zeroError;
        readData[CTL_INVERT]  = invertError;
        readData[CTL_PENDING] = pending;
        readData[CTL_LIMERR]  = limitErr;
      end
      REG_SETPOINT: readData[7:0] = shSetpoint;
      REG_GAINS: begin
        readData[4:0]   = shPosGain;
        readData[20:16] = shNegGain;
      end
      REG_ULIMIT: readData = shUpper;
      REG_LLIMIT: readData = shLower;
      REG_INT0:   readData[INT_W-1:0] = snap0;
      REG_INT1:   readData[INT_W-1:0] = snap1;
      REG_SQUELCH: begin
        readData[12:0]  = shSqLvl;
        readData[31:16] = shSqRatio;
      end
      default: readData = '0;
    endcase
  end

endmodule

// File: rtl/comb_agc_loop_regs_mc.sv
// comb_agc_loop_regs_mc
//   Multi-channel combiner AGC loop-filter register bank. Decodes the bus
//   address into channel and register index, fans byte-lane writes out to
//   NCHAN channel register blocks and multiplexes their readback.
// Ports
//   busClk, busRstN        clock, async active-low reset
//   addr                   byte address: [4:2] register, [4+CHW:5] channel
//   dataIn / dataOut       write data / combinational read data
//   cs, wr0..wr3           block select, byte-lane write enables
//   loopUpdate             per-channel loop sample strobes
//   integrator0/1          live integrators, INT_W bits per channel
//   agcSetpoint .. squelchRatio, invertError, zeroError   active register sets
//   committed              per-channel active-set update pulse
module comb_agc_loop_regs_mc
  import comb_agc_pkg::*;
#(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned INT_W = 32
) (
  input  logic                   busClk,
  input  logic                   busRstN,
  input  logic [12:0]            addr,
  input  logic [31:0]            dataIn,
  output logic [31:0]            dataOut,
  input  logic                   cs,
  input  logic                   wr0,
  input  logic                   wr1,
  input  logic                   wr2,
  input  logic                   wr3,
  input  logic [NCHAN-1:0]       loopUpdate,
  input  logic [NCHAN*INT_W-1:0] integrator0,
  input  logic [NCHAN*INT_W-1:0] integrator1,
  output logic [NCHAN*8-1:0]     agcSetpoint,
  output logic [NCHAN-1:0]       invertError,
  output logic [NCHAN-1:0]       zeroError,
  output logic [NCHAN*5-1:0]     posErrorGain,
  output logic [NCHAN*5-1:0]     negErrorGain,
  output logic [NCHAN*32-1:0]    upperLimit,
  output logic [NCHAN*32-1:0]    lowerLimit,
  output logic [NCHAN*13-1:0]    squelchLvl,
  output logic [NCHAN*16-1:0]    squelchRatio,
  output logic [NCHAN-1:0]       committed
);

  localparam int unsigned CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [CHW-1:0] chIdx;
  logic [2:0]     regIdx;
  logic           chValid;
  logic [3:0]     lanes;
  logic           unusedAddrBits;

  logic [3:0]  chLanes [NCHAN];
  logic [31:0] chRead  [NCHAN];

  assign chIdx   = addr[4+CHW:5];
  assign regIdx  = addr[4:2];
  assign chValid = (32'(chIdx) < NCHAN);
  assign lanes   = {wr3, wr2, wr1, wr0};

  // Byte offset and bits above the channel field do not take part in decode
  assign unusedAddrBits = ^{addr[12:5+CHW], addr[1:0]};

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    // Snapshot registers are read-only; writes aimed at them are dropped here
    assign chLanes[c] = (cs && chValid && chIdx == CHW'(c) &&
                         regIdx != REG_INT0 && regIdx != REG_INT1) ? lanes : '0;

    comb_agc_chan_regs #(
      .INT_W(INT_W)
    ) u_chan (
      .busClk      (busClk),
      .busRstN     (busRstN),
      .wrLane      (chLanes[c]),
      .regIdx      (regIdx),
      .dataIn      (dataIn),
      .loopUpdate  (loopUpdate[c]),
      .integrator0 (integrator0[c*INT_W +: INT_W]),
      .integrator1 (integrator1[c*INT_W +: INT_W]),
      .readData    (chRead[c]),
      .agcSetpoint (agcSetpoint[c*8 +: 8]),
      .invertError (invertError[c]),
      .zeroError   (zeroError[c]),
      .posErrorGain(posErrorGain[c*5 +: 5]),
      .negErrorGain(negErrorGain[c*5 +: 5]),
      .upperLimit  (upperLimit[c*32 +: 32]),
      .lowerLimit  (lowerLimit[c*32 +: 32]),
      .squelchLvl  (squelchLvl[c*13 +: 13]),
      .squelchRatio(squelchRatio[c*16 +: 16]),
      .committed   (committed[c])
    );
  end

  always_comb begin
    dataOut = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (cs && chValid && chIdx == CHW'(i)) dataOut = chRead[i];
    end
  end

endmodule

// File: tb/tb_comb_agc_loop_regs_mc.sv
module tb_comb_agc_loop_regs_mc;
  import comb_agc_pkg::*;

  logic         busClk = 1'b0;
  logic         busRstN = 1'b0;
  logic [12:0]  addr = '0;
  logic [31:0]  dataIn = '0;
  logic         cs = 1'b0;
  logic         wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
  logic [3:0]   loopUpdate = '0;
  logic [127:0] integrator0, integrator1;

  logic [31:0]  dataOut;
  logic [31:0]  agcSetpoint;
  logic [3:0]   invertError, zeroError, committed;
  logic [19:0]  posErrorGain, negErrorGain;
  logic [127:0] upperLimit, lowerLimit;
  logic [51:0]  squelchLvl;
  logic [63:0]  squelchRatio;

  // Three-channel instance: its channel field can address a missing channel
  logic [31:0]  dataOut3;
  logic [23:0]  agcSetpoint3;
  logic [2:0]   invertError3, zeroError3, committed3;
  logic [14:0]  posErrorGain3, negErrorGain3;
  logic [95:0]  upperLimit3, lowerLimit3;
  logic [38:0]  squelchLvl3;
  logic [47:0]  squelchRatio3;

  int unsigned tick = 0;
  int tests = 0;
  int fails = 0;

  always #5 busClk = ~busClk;

  initial forever begin
    @(negedge busClk);
    tick = tick + 1;
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      integrator0[c*32 +: 32] = tick * 256 + c;
      integrator1[c*32 +: 32] = 32'hA000_0000 + tick * 3 + c;
    end
  end

  comb_agc_loop_regs_mc #(.NCHAN(4), .INT_W(32)) dut (
    .busClk(busClk), .busRstN(busRstN), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .cs(cs), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .loopUpdate(loopUpdate), .integrator0(integrator0), .integrator1(integrator1),
    .agcSetpoint(agcSetpoint), .invertError(invertError), .zeroError(zeroError),
    .posErrorGain(posErrorGain), .negErrorGain(negErrorGain),
    .upperLimit(upperLimit), .lowerLimit(lowerLimit),
    .squelchLvl(squelchLvl), .squelchRatio(squelchRatio), .committed(committed)
  );

  comb_agc_loop_regs_mc #(.NCHAN(3), .INT_W(32)) dut3 (
    .busClk(busClk), .busRstN(busRstN), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut3), .cs(cs), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
    .loopUpdate(loopUpdate[2:0]), .integrator0(integrator0[95:0]),
    .integrator1(integrator1[95:0]),
    .agcSetpoint(agcSetpoint3), .invertError(invertError3), .zeroError(zeroError3),
    .posErrorGain(posErrorGain3), .negErrorGain(negErrorGain3),
    .upperLimit(upperLimit3), .lowerLimit(lowerLimit3),
    .squelchLvl(squelchLvl3), .squelchRatio(squelchRatio3), .committed(committed3)
  );

  task automatic bus_write(input int ch, input logic [2:0] idx,
                           input logic [31:0] d, input logic [3:0] lanes);
    @(negedge busClk);
    addr   = {6'b0, 2'(ch), idx, 2'b00};
    dataIn = d;
    cs     = 1'b1;
    {wr3, wr2, wr1, wr0} = lanes;
    @(negedge busClk);
    cs = 1'b0;
    {wr3, wr2, wr1, wr0} = 4'b0;
  endtask

  task automatic bus_read(input int ch, input logic [2:0] idx,
                          output logic [31:0] d, output logic [31:0] d3);
    @(negedge busClk);
    addr = {6'b0, 2'(ch), idx, 2'b00};
    cs   = 1'b1;
    {wr3, wr2, wr1, wr0} = 4'b0;
    #1;
    d  = dataOut;
    d3 = dataOut3;
    cs = 1'b0;
  endtask

  task automatic strobe(input int ch);
    @(negedge busClk);
    loopUpdate[ch] = 1'b1;
    @(negedge busClk);
    loopUpdate = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d, d3;
    busRstN = 1'b0;
    repeat (2) @(negedge busClk);
    busRstN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus_read(c, REG_SETPOINT, d, d3);
      tests++; if (d !== 32'h0000_00E0) begin fails++; $display("FAIL reset_setpoint ch%0d: got %h expected %h", c, d, 32'h0000_00E0); end
      bus_read(c, REG_GAINS, d, d3);
      tests++; if (d !== 32'h001B_001B) begin fails++; $display("FAIL reset_gains ch%0d: got %h expected %h", c, d, 32'h001B_001B); end
      bus_read(c, REG_ULIMIT, d, d3);
      tests++; if (d !== 32'h4FFF_FFFF) begin fails++; $display("FAIL reset_ulimit ch%0d: got %h expected %h", c, d, 32'h4FFF_FFFF); end
      bus_read(c, REG_LLIMIT, d, d3);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_llimit ch%0d: got %h expected %h", c, d, 32'h0); end
      bus_read(c, REG_SQUELCH, d, d3);
      tests++; if (d !== 32'h0042_0100) begin fails++; $display("FAIL reset_squelch ch%0d: got %h expected %h", c, d, 32'h0042_0100); end
      bus_read(c, REG_CONTROL, d, d3);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_control ch%0d: got %h expected %h", c, d, 32'h0); end
    end
    tests++; if (committed !== 4'b0) begin fails++; $display("FAIL reset_committed: got %b expected %b", committed, 4'b0); end
    tests++; if (agcSetpoint !== 32'hE0E0_E0E0) begin fails++; $display("FAIL reset_agcSetpoint: got %h expected %h", agcSetpoint, 32'hE0E0_E0E0); end
    tests++; if (posErrorGain !== {4{5'h1B}} || negErrorGain !== {4{5'h1B}}) begin fails++; $display("FAIL reset_gain_out: got %h/%h expected %h", posErrorGain, negErrorGain, {4{5'h1B}}); end
    tests++; if (upperLimit !== {4{32'h4FFF_FFFF}} || lowerLimit !== 128'h0) begin fails++; $display("FAIL reset_limits_out: got %h/%h", upperLimit, lowerLimit); end
    tests++; if (squelchLvl !== {4{13'h100}} || squelchRatio !== {4{16'h0042}}) begin fails++; $display("FAIL reset_squelch_out: got %h/%h", squelchLvl, squelchRatio); end
    tests++; if (invertError !== 4'b0 || zeroError !== 4'b0) begin fails++; $display("FAIL reset_err_ctl: got %b/%b expected 0000/0000", invertError, zeroError); end
  endtask

  task automatic test_shadow_commit();
    logic [31:0] d, d3;
    bus_write(2, REG_SETPOINT, 32'h80, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      strobe(2);
      tests++; if (committed !== 4'b0 || agcSetpoint !== 32'hE0E0_E0E0) begin fails++; $display("FAIL nocommit_strobe%0d: got %b %h expected 0000 %h", i, committed, agcSetpoint, 32'hE0E0_E0E0); end
    end
    bus_read(2, REG_SETPOINT, d, d3);
    tests++; if (d !== 32'h80) begin fails++; $display("FAIL shadow_readback: got %h expected %h", d, 32'h80); end
    bus_write(2, REG_CONTROL, 32'h4, 4'b0001);
    bus_read(2, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h100) begin fails++; $display("FAIL pending_set: got %h expected %h", d, 32'h100); end
    tests++; if (agcSetpoint !== 32'hE0E0_E0E0) begin fails++; $display("FAIL pending_noapply: got %h expected %h", agcSetpoint, 32'hE0E0_E0E0); end
    strobe(2);
    tests++; if (committed !== 4'b0100) begin fails++; $display("FAIL commit_pulse: got %b expected %b", committed, 4'b0100); end
    tests++; if (agcSetpoint !== 32'hE080_E0E0) begin fails++; $display("FAIL commit_apply: got %h expected %h", agcSetpoint, 32'hE080_E0E0); end
    @(negedge busClk);
    tests++; if (committed !== 4'b0) begin fails++; $display("FAIL commit_pulse_width: got %b expected %b", committed, 4'b0); end
    bus_read(2, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL pending_cleared: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_limit_err();
    logic [31:0] d, d3;
    bus_write(1, REG_LLIMIT, 32'h5000_0000, 4'hF);
    bus_write(1, REG_CONTROL, 32'h4, 4'b0001);
    strobe(1);
    tests++; if (committed !== 4'b0) begin fails++; $display("FAIL limit_nocommit: got %b expected %b", committed, 4'b0); end
    tests++; if (lowerLimit[63:32] !== 32'h0) begin fails++; $display("FAIL limit_active_kept: got %h expected %h", lowerLimit[63:32], 32'h0); end
    bus_read(1, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h200) begin fails++; $display("FAIL limit_err_set: got %h expected %h", d, 32'h200); end
    bus_read(1, REG_LLIMIT, d, d3);
    tests++; if (d !== 32'h5000_0000) begin fails++; $display("FAIL limit_shadow: got %h expected %h", d, 32'h5000_0000); end
    bus_write(1, REG_CONTROL, 32'h200, 4'b0010);
    bus_read(1, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL limit_err_clear: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_control_direct();
    logic [31:0] d, d3;
    bus_write(0, REG_CONTROL, 32'h3, 4'b0001);
    tests++; if (zeroError !== 4'b0001 || invertError !== 4'b0001) begin fails++; $display("FAIL ctl_direct: got %b/%b expected 0001/0001", zeroError, invertError); end
    bus_read(0, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL ctl_readback: got %h expected %h", d, 32'h3); end
    bus_write(0, REG_CONTROL, 32'h0, 4'b0001);
    tests++; if (zeroError !== 4'b0 || invertError !== 4'b0) begin fails++; $display("FAIL ctl_direct_clear: got %b/%b expected 0000/0000", zeroError, invertError); end
  endtask

  task automatic test_coincident();
    logic [31:0] d, d3;
    @(negedge busClk);
    addr   = {6'b0, 2'd0, REG_CONTROL, 2'b00};
    dataIn = 32'h4;
    cs     = 1'b1;
    wr0    = 1'b1;
    loopUpdate[0] = 1'b1;
    @(negedge busClk);
    cs = 1'b0;
    wr0 = 1'b0;
    loopUpdate = '0;
    tests++; if (committed !== 4'b0) begin fails++; $display("FAIL coinc_nocommit: got %b expected %b", committed, 4'b0); end
    bus_read(0, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h100) begin fails++; $display("FAIL coinc_pending: got %h expected %h", d, 32'h100); end
    bus_write(0, REG_CONTROL, 32'h4, 4'b0001);
    bus_write(0, REG_GAINS, 32'h0005_0007, 4'hF);
    tests++; if (posErrorGain[4:0] !== 5'h1B) begin fails++; $display("FAIL coinc_gain_held: got %h expected %h", posErrorGain[4:0], 5'h1B); end
    strobe(0);
    tests++; if (committed !== 4'b0001) begin fails++; $display("FAIL coinc_commit: got %b expected %b", committed, 4'b0001); end
    tests++; if (posErrorGain !== {5'h1B, 5'h1B, 5'h1B, 5'h07} || negErrorGain !== {5'h1B, 5'h1B, 5'h1B, 5'h05}) begin fails++; $display("FAIL coinc_gains: got %h/%h", posErrorGain, negErrorGain); end
    strobe(0);
    tests++; if (committed !== 4'b0) begin fails++; $display("FAIL no_double_apply: got %b expected %b", committed, 4'b0); end
  endtask

  task automatic test_snapshot();
    logic [31:0] d, d3, e0, e1;
    int unsigned capTick;
    @(negedge busClk);
    addr   = {6'b0, 2'd3, REG_CONTROL, 2'b00};
    dataIn = 32'h8;
    cs     = 1'b1;
    wr0    = 1'b1;
    #1 capTick = tick;
    @(negedge busClk);
    cs = 1'b0;
    wr0 = 1'b0;
    e0 = capTick * 256 + 3;
    e1 = 32'hA000_0000 + capTick * 3 + 3;
    bus_read(3, REG_INT0, d, d3);
    tests++; if (d !== e0) begin fails++; $display("FAIL snap_int0: got %h expected %h", d, e0); end
    bus_read(3, REG_INT1, d, d3);
    tests++; if (d !== e1) begin fails++; $display("FAIL snap_int1: got %h expected %h", d, e1); end
    repeat (3) @(negedge busClk);
    bus_read(3, REG_INT0, d, d3);
    tests++; if (d !== e0) begin fails++; $display("FAIL snap_int0_static: got %h expected %h", d, e0); end
    bus_read(3, REG_INT1, d, d3);
    tests++; if (d !== e1) begin fails++; $display("FAIL snap_int1_static: got %h expected %h", d, e1); end
    bus_read(2, REG_INT0, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL snap_other_ch: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid_commit();
    logic [31:0] d, d3;
    bus_write(2, REG_SETPOINT, 32'h33, 4'b0001);
    bus_write(2, REG_CONTROL, 32'h4, 4'b0001);
    bus_read(2, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h100) begin fails++; $display("FAIL rst_pre_pending: got %h expected %h", d, 32'h100); end
    @(negedge busClk);
    #2 busRstN = 1'b0;
    #1;
    tests++; if (agcSetpoint !== 32'hE0E0_E0E0 || committed !== 4'b0) begin fails++; $display("FAIL rst_async: got %h %b expected %h 0000", agcSetpoint, committed, 32'hE0E0_E0E0); end
    tests++; if (posErrorGain !== {4{5'h1B}} || negErrorGain !== {4{5'h1B}}) begin fails++; $display("FAIL rst_async_gains: got %h/%h expected %h", posErrorGain, negErrorGain, {4{5'h1B}}); end
    @(negedge busClk);
    busRstN = 1'b1;
    strobe(2);
    tests++; if (committed !== 4'b0 || agcSetpoint !== 32'hE0E0_E0E0) begin fails++; $display("FAIL rst_no_commit: got %b %h expected 0000 %h", committed, agcSetpoint, 32'hE0E0_E0E0); end
    bus_read(2, REG_CONTROL, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_pending_clr: got %h expected %h", d, 32'h0); end
    bus_read(2, REG_SETPOINT, d, d3);
    tests++; if (d !== 32'hE0) begin fails++; $display("FAIL rst_shadow: got %h expected %h", d, 32'hE0); end
    bus_read(3, REG_INT0, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_snapshot: got %h expected %h", d, 32'h0); end
    // Out-of-range channel on the three-channel instance
    bus_write(3, REG_SETPOINT, 32'h55, 4'b0001);
    bus_read(3, REG_SETPOINT, d, d3);
    tests++; if (d3 !== 32'h0) begin fails++; $display("FAIL oor_read: got %h expected %h", d3, 32'h0); end
    tests++; if (d !== 32'h55) begin fails++; $display("FAIL inrange_ch3: got %h expected %h", d, 32'h55); end
    tests++; if (agcSetpoint3 !== 24'hE0E0E0) begin fails++; $display("FAIL oor_no_alias: got %h expected %h", agcSetpoint3, 24'hE0E0E0); end
    bus_read(0, REG_SETPOINT, d, d3);
    tests++; if (d3 !== 32'hE0) begin fails++; $display("FAIL dut3_ch0: got %h expected %h", d3, 32'hE0); end
    // Snapshot registers are read-only
    bus_write(0, REG_INT0, 32'hFFFF_FFFF, 4'hF);
    bus_read(0, REG_INT0, d, d3);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL int0_ro: got %h expected %h", d, 32'h0); end
    // Deselected reads return zero
    @(negedge busClk);
    addr = {6'b0, 2'd0, REG_SETPOINT, 2'b00};
    cs = 1'b0;
    #1;
    tests++; if (dataOut !== 32'h0) begin fails++; $display("FAIL cs_low_read: got %h expected %h", dataOut, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_shadow_commit();
    test_limit_err();
    test_control_direct();
    test_coincident();
    test_snapshot();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
